mod_updown_counter: RTL and testbench



---
 rtl/mod_updown_counter.sv | 62 ++++++
 tb/tb_mod_updown_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, parallel load, wrap/saturate mode,
// sticky overflow flag and a combinational terminal count for cascading.
module mod_updown_counter #(
  parameter int unsigned N   = 4,
  parameter int unsigned MOD = 2**N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         cnten,
  input  logic         up,
  input  logic         sat,
  input  logic         ld,
  input  logic [N-1:0] ldval,
  input  logic         ovclr,
  output logic [N-1:0] out,
  output logic         tc,
  output logic         ov
);

  // The modulus may equal 2**N, so form the max value one bit wider before narrowing.
  localparam logic [N:0]   MAXV_WIDE = (N+1)'(MOD - 1);
  localparam logic [N-1:0] MAXV      = MAXV_WIDE[N-1:0];

  logic [N-1:0] out_q, out_d;
  logic         ov_q, ov_d;
  logic         at_end;

  assign at_end = up ? (out_q == MAXV) : (out_q == '0);
  assign tc     = cnten & ~ld & ~clr & at_end;
  assign out    = out_q;
  assign ov     = ov_q;

  // Next-state: clr > ld > count > hold; an overflow event beats ovclr.
  always_comb begin
    out_d = out_q;
    ov_d  = ov_q;
    if (ovclr) begin
      ov_d = 1'b0;
    end
    if (clr) begin
      out_d = '0;
      ov_d  = 1'b0;
    end else if (ld) begin
      out_d = (ldval > MAXV) ? MAXV : ldval;
    end else if (cnten) begin
      if (at_end) begin
        ov_d = 1'b1;
        if (!sat) begin
          out_d = up ? '0 : MAXV;
        end
      end else begin
        out_d = up ? (out_q + N'(1)) : (out_q - N'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
    ov_q  <= ov_d;
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (MOD=16, MOD=10, cascade).
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       clr, cnten, up, sat, ld, ovclr;
  logic [3:0] ldval;
  logic [3:0] out16, out10;
  logic       tc16, tc10, ov16, ov10;

  logic       clr_c, cnten_c;
  logic [3:0] out_lo, out_hi;
  logic       tc_lo, tc_hi, ov_lo, ov_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.N(4), .MOD(16)) u_dut16 (
    .clk(clk), .clr(clr), .cnten(cnten), .up(up), .sat(sat), .ld(ld),
    .ldval(ldval), .ovclr(ovclr), .out(out16), .tc(tc16), .ov(ov16)
  );

  mod_updown_counter #(.N(4), .MOD(10)) u_dut10 (
    .clk(clk), .clr(clr), .cnten(cnten), .up(up), .sat(sat), .ld(ld),
    .ldval(ldval), .ovclr(ovclr), .out(out10), .tc(tc10), .ov(ov10)
  );

  mod_updown_counter #(.N(4), .MOD(16)) u_lo (
    .clk(clk), .clr(clr_c), .cnten(cnten_c), .up(1'b1), .sat(1'b0), .ld(1'b0),
    .ldval(4'd0), .ovclr(1'b0), .out(out_lo), .tc(tc_lo), .ov(ov_lo)
  );

  mod_updown_counter #(.N(4), .MOD(16)) u_hi (
    .clk(clk), .clr(clr_c), .cnten(tc_lo), .up(1'b1), .sat(1'b0), .ld(1'b0),
    .ldval(4'd0), .ovclr(1'b0), .out(out_hi), .tc(tc_hi), .ov(ov_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cur;
    int ovexp;
    clr = 1'b1; cnten = 1'b0; up = 1'b1; sat = 1'b0; ld = 1'b0;
    ldval = 4'd0; ovclr = 1'b0;
    clr_c = 1'b1; cnten_c = 1'b0;
    step();

    // clr dominates tc even with a counting request at the terminal value
    cnten = 1'b1; up = 1'b0; #1;
    check("tc_during_clr", 32'(tc16), 32'd0);
    cnten = 1'b0; up = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_out", 32'(out16), 32'd0);
      check("hold_ov", 32'(ov16), 32'd0);
      check("hold_tc", 32'(tc16), 32'd0);
    end

    // Up-wrap on MOD=10
    up = 1'b1; sat = 1'b0; cnten = 1'b1; #1;
    cur = 0;
    for (int i = 1; i <= 12; i++) begin
      check("upwrap_tc", 32'(tc10), (cur == 9) ? 32'd1 : 32'd0);
      step();
      cur = i % 10;
      check("upwrap_out", 32'(out10), 32'(cur));
      check("upwrap_ov", 32'(ov10), (i >= 10) ? 32'd1 : 32'd0);
    end

    // Down-saturate: load 2 (clearing ov on the same edge), then count down
    cnten = 1'b0; ld = 1'b1; ldval = 4'd2; ovclr = 1'b1;
    step();
    ld = 1'b0; ovclr = 1'b0;
    check("dsat_load", 32'(out10), 32'd2);
    check("dsat_ovclr", 32'(ov10), 32'd0);
    up = 1'b0; sat = 1'b1; cnten = 1'b1; #1;
    cur = 2; ovexp = 0;
    for (int i = 0; i < 4; i++) begin
      check("dsat_tc", 32'(tc10), (cur == 0) ? 32'd1 : 32'd0);
      step();
      if (cur == 0) ovexp = 1;
      else cur = cur - 1;
      check("dsat_out", 32'(out10), 32'(cur));
      check("dsat_ov", 32'(ov10), 32'(ovexp));
    end

    // Load clamp (cnten ignored, ov untouched), then clr beating ld
    up = 1'b1; sat = 1'b0; cnten = 1'b1; ld = 1'b1; ldval = 4'd13; #1;
    check("ld_tc_blocked", 32'(tc10), 32'd0);
    step();
    check("ld_clamp10", 32'(out10), 32'd9);
    check("ld_noclamp16", 32'(out16), 32'd13);
    check("ld_ov_kept", 32'(ov10), 32'd1);
    clr = 1'b1; ldval = 4'd5;
    step();
    clr = 1'b0; ld = 1'b0; cnten = 1'b0;
    check("clr_ld_out", 32'(out10), 32'd0);
    check("clr_ld_ov", 32'(ov10), 32'd0);

    // ovclr race on MOD=16: overflow set wins, then ovclr alone clears
    ld = 1'b1; ldval = 4'd15;
    step();
    ld = 1'b0;
    check("race_load", 32'(out16), 32'd15);
    cnten = 1'b1; up = 1'b1; ovclr = 1'b1; #1;
    check("race_tc", 32'(tc16), 32'd1);
    step();
    check("race_out", 32'(out16), 32'd0);
    check("race_ov", 32'(ov16), 32'd1);
    cnten = 1'b0;
    step();
    ovclr = 1'b0;
    check("ovclr_ov", 32'(ov16), 32'd0);
    check("ovclr_out", 32'(out16), 32'd0);

    // Up-saturate at 15 holds and sets ov
    ld = 1'b1; ldval = 4'd15;
    step();
    ld = 1'b0; sat = 1'b1; cnten = 1'b1;
    step();
    cnten = 1'b0; sat = 1'b0;
    check("usat_out", 32'(out16), 32'd15);
    check("usat_ov", 32'(ov16), 32'd1);

    // Cascade: 300 counts -> 0x2C
    clr_c = 1'b0; cnten_c = 1'b1;
    for (int i = 0; i < 300; i++) step();
    cnten_c = 1'b0; #1;
    check("casc_lo", 32'(out_lo), 32'd12);
    check("casc_hi", 32'(out_hi), 32'd2);
    check("casc_hi_ov", 32'(ov_hi), 32'd1);
    check("casc_tc_idle", 32'(tc_lo), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
